// File: rtl/ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ifetch_ctrl                                                      |
// | Brief   : Fetch PC sequencer with 2-entry prefetch buffer and redirect.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ifetch_ctrl #(
  parameter  int S        = 32,
  parameter  int L        = 256,
  parameter  int RESET_PC = 0,
  parameter  int WRAP     = 1,
  localparam int AW       = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] mem_a,
  input  logic [S-1:0]  mem_d,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [S-1:0]  instr,
  output logic [AW-1:0] instr_pc,
  output logic [1:0]    fifo_count,
  output logic          at_end
);

  localparam logic [1:0]    c_idle     = 2'd0;
  localparam logic [1:0]    c_run      = 2'd1;
  localparam logic [1:0]    c_end      = 2'd2;
  localparam logic [AW-1:0] c_last_pc  = AW'(L - 1);
  localparam logic [AW-1:0] c_reset_pc = AW'(RESET_PC);
  localparam logic [AW-1:0] c_pc_one   = AW'(1);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          w_run;
  logic          w_end;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_next;
  logic          w_pc_at_last;
  logic [1:0]    r_cnt;
  logic [S-1:0]  r_d0;
  logic [S-1:0]  r_d1;
  logic [AW-1:0] r_pc0;
  logic [AW-1:0] r_pc1;
  logic          w_pop;
  logic          w_push;

  // Redirect suppresses both ends of the buffer in the cycle it is seen.
  assign w_pop        = (r_cnt != 2'd0) & instr_ready & ~redirect;
  assign w_push       = w_run & en & ((r_cnt != 2'd2) | w_pop) & ~redirect;
  assign w_pc_at_last = (r_pc == c_last_pc);
  assign w_pc_next    = w_pc_at_last ? ((WRAP != 0) ? '0 : c_last_pc)
                                     : r_pc + c_pc_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect) begin
      w_next_state = en ? c_run : c_idle;
    end else begin
      case (r_state)
        c_idle:  if (en) w_next_state = c_run;
        c_run: begin
          if (!en)
            w_next_state = c_idle;
          else if (w_push && w_pc_at_last && (WRAP == 0))
            w_next_state = c_end;
        end
        c_end:   w_next_state = c_end;
        default: w_next_state = c_idle;
      endcase
    end
  end

  always_comb begin
    w_run = (r_state == c_run);
    w_end = (r_state == c_end);
  end

  // Entry 0 is always the head; entry 1 only exists when two are held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= c_reset_pc;
      r_cnt <= 2'd0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_pc0 <= '0;
      r_pc1 <= '0;
    end else if (redirect) begin
      r_pc  <= redirect_pc;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_pc <= w_pc_next;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_d0  <= mem_d;
            r_pc0 <= r_pc;
          end else begin
            r_d1  <= mem_d;
            r_pc1 <= r_pc;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd2) begin
            r_d0  <= r_d1;
            r_pc0 <= r_pc1;
          end
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0  <= mem_d;
            r_pc0 <= r_pc;
          end else begin
            r_d0  <= r_d1;
            r_pc0 <= r_pc1;
            r_d1  <= mem_d;
            r_pc1 <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a       = r_pc;
  assign instr_valid = (r_cnt != 2'd0);
  assign instr       = r_d0;
  assign instr_pc    = r_pc0;
  assign fifo_count  = r_cnt;
  assign at_end      = w_end;

endmodule
`default_nettype wire
